// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Groups the PLL/core reset sequencing signals of pll_reset_sequencer.
//   master : the sequencer (drives resets and status, receives lock and
//            software request)
//   slave  : the environment (PLL model / software / status consumer)
// Signals:
//   pllLocked     PLL LOCK, asynchronous to the reference clock
//   swReset       single-cycle request for a full re-sequence
//   pllResetN     to PLL RESETB
//   coreResetN    core reset, active-low
//   state         current FSM state encoding
//   retries       PLL reset retries used in the current bring-up
//   failed        high while in FAILED
//   lockLossCount saturating count of lock losses seen in RUN
interface pll_reset_sequencer_if;
    logic       pllLocked;
    logic       swReset;
    logic       pllResetN;
    logic       coreResetN;
    logic [2:0] state;
    logic [3:0] retries;
    logic       failed;
    logic [7:0] lockLossCount;

    modport master (
        input  pllLocked, swReset,
        output pllResetN, coreResetN, state, retries, failed, lockLossCount
    );

    modport slave (
        output pllLocked, swReset,
        input  pllResetN, coreResetN, state, retries, failed, lockLossCount
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings up the SB_PLL40_CORE and releases the core reset once lock has
//   been stable long enough; re-sequences on lock loss or software request.
//   Runs entirely on the 12 MHz reference clock.
// Ports:
//   clkIn   12 MHz reference clock
//   resetN  asynchronous active-low reset
//   bus     pll_reset_sequencer_if.master (lock in, sw request in, resets
//           and status out)
// Configuration macro:
//   PLL_SEQ_RETRY_EN  enables WAIT_LOCK timeout, retry counting and FAILED.
//                     When undefined WAIT_LOCK waits indefinitely and
//                     retries/failed read as 0.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
    parameter int unsigned RELEASE_DELAY_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int unsigned MAX_RETRIES          = 3,
    parameter int unsigned CNT_W                = 17
) (
    input  logic                  clkIn,
    input  logic                  resetN,
    pll_reset_sequencer_if.master bus
);

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RELEASE   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] FAILED    = 3'd5;

    // A state of length N exits when the counter reaches N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);

    logic [1:0]       lockSyncQ;
    logic             lockSync;
    logic [2:0]       stateQ, stateD;
    logic [CNT_W-1:0] cntQ;
    logic [7:0]       lossQ, lossD;
    logic             pllResetNQ, coreResetNQ;

`ifdef PLL_SEQ_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic [3:0] retriesQ, retriesD;
    logic       failedQ;
`else
    logic unusedCfg;
    assign unusedCfg = ^{LOCK_TIMEOUT_CYCLES, MAX_RETRIES};
`endif

    assign lockSync = lockSyncQ[1];

    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            lockSyncQ <= '0;
        end else begin
            lockSyncQ <= {lockSyncQ[0], bus.pllLocked};
        end
    end

    always_comb begin
        stateD = stateQ;
        lossD  = lossQ;
`ifdef PLL_SEQ_RETRY_EN
        retriesD = retriesQ;
`endif
        if (bus.swReset) begin
            // Software request outranks everything, including lock loss.
            stateD = PLL_RST;
`ifdef PLL_SEQ_RETRY_EN
            retriesD = '0;
`endif
        end else begin
            case (stateQ)
                PLL_RST: begin
                    if (cntQ == RST_LAST) stateD = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still wins.
                    if (lockSync) begin
                        stateD = STABLE;
                    end
`ifdef PLL_SEQ_RETRY_EN
                    else if (cntQ == TIMEOUT_LAST) begin
                        if (retriesQ == RETRY_MAX) begin
                            stateD = FAILED;
                        end else begin
                            retriesD = retriesQ + 4'd1;
                            stateD   = PLL_RST;
                        end
                    end
`endif
                end
                STABLE: begin
                    if (!lockSync)                stateD = WAIT_LOCK;
                    else if (cntQ == STABLE_LAST) stateD = RELEASE;
                end
                RELEASE: begin
                    if (!lockSync)                 stateD = WAIT_LOCK;
                    else if (cntQ == RELEASE_LAST) stateD = RUN;
                end
                RUN: begin
                    if (!lockSync) begin
                        if (lossQ != 8'hFF) lossD = lossQ + 8'd1;
                        stateD = PLL_RST;
                    end
                end
`ifdef PLL_SEQ_RETRY_EN
                FAILED: stateD = FAILED;
`endif
                default: stateD = PLL_RST;
            endcase
        end
`ifdef PLL_SEQ_RETRY_EN
        if (stateD == RUN) retriesD = '0;
`endif
    end

    // Outputs are decoded from the next state so they switch together
    // with the state register.
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            stateQ      <= PLL_RST;
            cntQ        <= '0;
            lossQ       <= '0;
            pllResetNQ  <= 1'b0;
            coreResetNQ <= 1'b0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= (bus.swReset || (stateD != stateQ)) ? '0 : cntQ + CNT_W'(1);
            lossQ       <= lossD;
            pllResetNQ  <= !((stateD == PLL_RST) || (stateD == FAILED));
            coreResetNQ <= (stateD == RUN);
        end
    end

`ifdef PLL_SEQ_RETRY_EN
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            retriesQ <= '0;
            failedQ  <= 1'b0;
        end else begin
            retriesQ <= retriesD;
            failedQ  <= (stateD == FAILED);
        end
    end

    assign bus.retries = retriesQ;
    assign bus.failed  = failedQ;
`else
    assign bus.retries = '0;
    assign bus.failed  = 1'b0;
`endif

    assign bus.state         = stateQ;
    assign bus.pllResetN     = pllResetNQ;
    assign bus.coreResetN    = coreResetNQ;
    assign bus.lockLossCount = lossQ;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with short cycle parameters
//   (reset 4, stable 8, release 4, timeout 32, max retries 2). Expected
//   values adapt to whether PLL_SEQ_RETRY_EN is defined for the build.
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clkIn  = 1'b0;
    logic resetN = 1'b1;
    int   passed = 0;
    int   total  = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .RELEASE_DELAY_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (17)
    ) dut (
        .clkIn (clkIn),
        .resetN(resetN),
        .bus   (bus.master)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        string       name;
        logic        locked;
        logic        sw;
        int unsigned cycles;
        logic [2:0]  st;
        logic        prn;
        logic        crn;
        logic [3:0]  ret;
        logic        f;
        logic [7:0]  llc;
    } vec_t;

    vec_t tbl[$];

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic prn,
                         input logic crn, input logic [3:0] ret, input logic f,
                         input logic [7:0] llc);
        logic [17:0] act;
        logic [17:0] req;
        act = {bus.state, bus.pllResetN, bus.coreResetN, bus.retries, bus.failed, bus.lockLossCount};
        req = {st, prn, crn, ret, f, llc};
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got state=%0d pllResetN=%b coreResetN=%b retries=%0d failed=%b lossCount=%0d, required state=%0d pllResetN=%b coreResetN=%b retries=%0d failed=%b lossCount=%0d",
                     name, bus.state, bus.pllResetN, bus.coreResetN, bus.retries, bus.failed,
                     bus.lockLossCount, st, prn, crn, ret, f, llc);
        end
    endtask

    task automatic add(input string name, input logic locked, input logic sw,
                       input int unsigned cycles, input logic [2:0] st, input logic prn,
                       input logic crn, input logic [3:0] ret, input logic f,
                       input logic [7:0] llc);
        vec_t v;
        v.name = name; v.locked = locked; v.sw = sw; v.cycles = cycles;
        v.st = st; v.prn = prn; v.crn = crn; v.ret = ret; v.f = f; v.llc = llc;
        tbl.push_back(v);
    endtask

    task automatic runTable();
        foreach (tbl[i]) begin
            bus.pllLocked = tbl[i].locked;
            bus.swReset   = tbl[i].sw;
            tick(tbl[i].cycles);
            check(tbl[i].name, tbl[i].st, tbl[i].prn, tbl[i].crn, tbl[i].ret, tbl[i].f, tbl[i].llc);
        end
        bus.swReset = 1'b0;
        tbl.delete();
    endtask

    initial begin
        bus.pllLocked = 1'b0;
        bus.swReset   = 1'b0;
        #2 resetN = 1'b0;
        tick(2);
        check("resetValues", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
        resetN = 1'b1;

        // Normal bring-up: lock raised 10 cycles after release, STABLE
        // entered on edge 13, RUN on edge 25.
        add("bu_pllRst",   1'b0, 1'b0, 3,  3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_waitLock", 1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_waiting",  1'b0, 1'b0, 6,  3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_syncLag",  1'b1, 1'b0, 2,  3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_stable",   1'b1, 1'b0, 1,  3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_release",  1'b1, 1'b0, 11, 3'd3, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("bu_run",      1'b1, 1'b0, 1,  3'd4, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0);
        runTable();

        // Lock loss in RUN: core reset drops on the 3rd edge.
        bus.pllLocked = 1'b0;
        tick(2);
        check("loss_edge2", 3'd4, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0);
        tick(1);
        check("loss_edge3", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd1);
        bus.pllLocked = 1'b1;
        tick(3);
        check("loss_pulseEnd", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("loss_waitLock", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("loss_stable", 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);

        // Glitch at STABLE count 5: lockSync falls just as count 7 is reached.
        tick(5);
        check("gl_count5", 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        bus.pllLocked = 1'b0;
        tick(2);
        check("gl_count7", 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        bus.pllLocked = 1'b1;
        tick(1);
        check("gl_backToWait", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("gl_stillWait", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("gl_stableAgain", 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(11);
        check("gl_release", 3'd3, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("gl_run", 3'd4, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1);

        // swReset in the cycle lockSync falls: swReset wins, no loss counted.
        bus.pllLocked = 1'b0;
        tick(2);
        bus.swReset = 1'b1;
        tick(1);
        bus.swReset = 1'b0;
        check("swVsLoss", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd1);

        // Timeout cycle coincides with lockSync rising: lock wins.
        tick(33);
        bus.pllLocked = 1'b1;
        tick(2);
        check("to_count31", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(1);
        check("toVsLock", 3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
        tick(8);
        check("to_release", 3'd3, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);

        // Asynchronous reset mid-RELEASE, checked between clock edges.
        tick(2);
        #3 resetN = 1'b0;
        #1;
        check("asyncReset", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
        bus.pllLocked = 1'b0;
        tick(2);
        resetN = 1'b1;

        // Lock never asserted: retries, FAILED, then swReset recovery.
        add("ln_wait",    1'b0, 1'b0, 4,  3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("ln_preTo1",  1'b0, 1'b0, 31, 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        add("ln_retry1",  1'b0, 1'b0, 1,  RETRY ? 3'd0 : 3'd1, !RETRY, 1'b0, RETRY ? 4'd1 : 4'd0, 1'b0, 8'd0);
        add("ln_pulse1",  1'b0, 1'b0, 3,  RETRY ? 3'd0 : 3'd1, !RETRY, 1'b0, RETRY ? 4'd1 : 4'd0, 1'b0, 8'd0);
        add("ln_wait2",   1'b0, 1'b0, 1,  3'd1, 1'b1, 1'b0, RETRY ? 4'd1 : 4'd0, 1'b0, 8'd0);
        add("ln_preTo2",  1'b0, 1'b0, 31, 3'd1, 1'b1, 1'b0, RETRY ? 4'd1 : 4'd0, 1'b0, 8'd0);
        add("ln_retry2",  1'b0, 1'b0, 1,  RETRY ? 3'd0 : 3'd1, !RETRY, 1'b0, RETRY ? 4'd2 : 4'd0, 1'b0, 8'd0);
        add("ln_wait3",   1'b0, 1'b0, 4,  3'd1, 1'b1, 1'b0, RETRY ? 4'd2 : 4'd0, 1'b0, 8'd0);
        add("ln_preTo3",  1'b0, 1'b0, 31, 3'd1, 1'b1, 1'b0, RETRY ? 4'd2 : 4'd0, 1'b0, 8'd0);
        add("ln_failed",  1'b0, 1'b0, 1,  RETRY ? 3'd5 : 3'd1, !RETRY, 1'b0, RETRY ? 4'd2 : 4'd0, RETRY, 8'd0);
        add("ln_hold",    1'b0, 1'b0, 10, RETRY ? 3'd5 : 3'd1, !RETRY, 1'b0, RETRY ? 4'd2 : 4'd0, RETRY, 8'd0);
        add("ln_swReset", 1'b0, 1'b1, 1,  3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
        add("ln_after",   1'b0, 1'b0, 4,  3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
        runTable();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
